// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode map, FSM state type and
// the opcode classifier used by the decode stage.
package seq_pkg;

    // Datapath opcodes, handed to the execute unit untouched.
    localparam logic [4:0] OP_MOVSGPR = 5'b00000;
    localparam logic [4:0] OP_MOVGPRS = 5'b00001;
    localparam logic [4:0] OP_ADD     = 5'b00010;
    localparam logic [4:0] OP_SUB     = 5'b00011;
    localparam logic [4:0] OP_AND     = 5'b00100;
    localparam logic [4:0] OP_OR      = 5'b00101;
    localparam logic [4:0] OP_XOR     = 5'b00110;
    localparam logic [4:0] OP_SHIFT   = 5'b00111;
    localparam logic [4:0] OP_LOAD    = 5'b01000;
    localparam logic [4:0] OP_STORE   = 5'b01001;

    // Control opcodes resolved inside the sequencer.
    localparam logic [4:0] OP_JUMP    = 5'b01010;
    localparam logic [4:0] OP_HALT    = 5'b01111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StWait,
        StHalt
    } seq_state_e;

    function automatic logic is_datapath_op(input logic [4:0] opcode);
        return opcode <= OP_STORE;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch port and execute-unit issue port of the sequencer.
// master = sequencer side, slave = memory / execute side.
interface instr_sequencer_if #(
    parameter int unsigned PC_W = 8
) ();

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    logic            ex_valid;
    logic [31:0]     ex_ir;
    logic            ex_ready;
    logic            ex_done;

    modport master (
        output imem_req, imem_addr, ex_valid, ex_ir,
        input  imem_ack, imem_rdata, ex_ready, ex_done
    );

    modport slave (
        input  imem_req, imem_addr, ex_valid, ex_ir,
        output imem_ack, imem_rdata, ex_ready, ex_done
    );

endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/issue controller: fetches into IR, resolves jump/halt/illegal locally and
// issues datapath instructions to the execute unit. All outputs come from flops only.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [PC_W-1:0]     start_pc,
    input  logic                stop,
    instr_sequencer_if.master   bus,
    output logic                busy,
    output logic                halted,
    output logic                err,
    output logic [PC_W-1:0]     pc,
    output logic [15:0]         instr_count
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            err_q, err_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [4:0]      opcode;
    logic [15:0]     cnt_inc;
    seq_state_e      fetch_or_halt;

    assign opcode  = ir_q[31:27];
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // stop is evaluated on every transition into FETCH so no request is ever raised
    // for an instruction that will not run.
    assign fetch_or_halt = stop ? StHalt : StFetch;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    pc_d    = start_pc;
                    err_d   = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = fetch_or_halt;
                end
            end
            StFetch: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (opcode == OP_HALT) begin
                    state_d = StHalt;
                end else if (opcode == OP_JUMP) begin
                    pc_d    = ir_q[PC_W-1:0];
                    cnt_d   = cnt_inc;
                    state_d = fetch_or_halt;
                end else if (is_datapath_op(opcode)) begin
                    state_d = StIssue;
                end else begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end
            end
            StIssue: begin
                if (bus.ex_ready) begin
                    pc_d = pc_q + PC_W'(1);
                    if (bus.ex_done) begin
                        cnt_d   = cnt_inc;
                        state_d = fetch_or_halt;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (bus.ex_done) begin
                    cnt_d   = cnt_inc;
                    state_d = fetch_or_halt;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_req  = (state_q == StFetch);
    assign bus.imem_addr = pc_q;
    assign bus.ex_valid  = (state_q == StIssue);
    assign bus.ex_ir     = ir_q;

    assign busy        = (state_q != StIdle) && (state_q != StHalt);
    assign halted      = (state_q == StHalt);
    assign err         = err_q;
    assign pc          = pc_q;
    assign instr_count = cnt_q;

endmodule
